// File: rtl/dram_device_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dram_pkg
//  Purpose  : Shared types and constants for the single-bank DRAM responder.
//             Holds the bank state encoding, the all-ones "read" write-enable
//             code, the data width and the default timing constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,   // row closed
        ACTIVE = 2'd1,   // row open
        PRECHG = 2'd2    // precharge in progress
    } dram_state_t;

    localparam logic [3:0] DRAM_WEN_READ = 4'hF;
    localparam int         DATA_W        = 32;
    localparam int         NBYTES        = DATA_W / 8;

    localparam int DEF_ROW_BITS = 11;
    localparam int DEF_COL_BITS = 10;
    localparam int DEF_MEM_AW   = 16;
    localparam int DEF_CAS_LAT  = 5;
    localparam int DEF_T_RCD    = 2;
    localparam int DEF_T_RP     = 3;

endpackage
`default_nettype wire

// File: rtl/dram_device_model_bank_array.sv
`default_nettype none
// ============================================================================
//  Module   : dram_bank_array
//  Purpose  : Storage for the DRAM responder. 2**AW words of DATA_W bits with
//             per-byte synchronous write and an asynchronous read port.
//  Ports    : clk      - clock
//             i_we     - per-byte write enables (active high)
//             i_waddr  - write word address
//             i_wdata  - write data
//             i_raddr  - read word address
//             o_rdata  - read data (combinational from i_raddr)
//  Revision : 1.0  initial release
// ============================================================================
module dram_bank_array
    import dram_pkg::*;
#(
    parameter int AW = DEF_MEM_AW
) (
    input  logic              clk,
    input  logic [NBYTES-1:0] i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Contents are deliberately not reset.
    logic [DATA_W-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (i_we[i]) begin
                r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/dram_device_model.sv
`default_nettype none
// ============================================================================
//  Module   : dram_device_model
//  Purpose  : Synthesizable single-bank DRAM responder (device end of the
//             DRAM pin interface). Decodes activate / precharge / CAS from
//             strobe edges, performs zero-latency byte-masked writes and
//             returns read data CAS_LAT cycles after the read CAS.
//  Ports    : clk, rst                 - clock, synchronous active-high reset
//             DRAM_CSn                 - chip select (active low)
//             DRAM_RASn / DRAM_CASn    - row / column strobes (active low)
//             DRAM_WEn[3:0]            - byte write enables, 4'hF = read
//             DRAM_A                   - multiplexed row/column address
//             DRAM_D                   - write data
//             DRAM_Q / DRAM_valid      - read data and one-cycle strobe
//             proto_err                - sticky protocol-violation flag
//  Options  : DRAM_TIMING_CHECK_EN - when defined, tRCD and tRP are counted
//             and enforced; otherwise CAS is legal the cycle after activate
//             and precharge lasts a single cycle.
//  Revision : 1.0  initial release
// ============================================================================
module dram_device_model
    import dram_pkg::*;
#(
    parameter int ROW_BITS = DEF_ROW_BITS,
    parameter int COL_BITS = DEF_COL_BITS,
    parameter int MEM_AW   = DEF_MEM_AW,
    parameter int CAS_LAT  = DEF_CAS_LAT,
    parameter int T_RCD    = DEF_T_RCD,
    parameter int T_RP     = DEF_T_RP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                DRAM_CSn,
    input  logic                DRAM_RASn,
    input  logic                DRAM_CASn,
    input  logic [NBYTES-1:0]   DRAM_WEn,
    input  logic [ROW_BITS-1:0] DRAM_A,
    input  logic [DATA_W-1:0]   DRAM_D,
    output logic [DATA_W-1:0]   DRAM_Q,
    output logic                DRAM_valid,
    output logic                proto_err
);

    localparam int RCW = $clog2(CAS_LAT);
    localparam logic [RCW-1:0] c_RD_LOAD = RCW'(CAS_LAT - 1);

    // ------------------------------------------------------------------
    // Strobe edge detection
    // ------------------------------------------------------------------
    logic r_rasn_q;
    logic r_casn_q;
    logic w_act;
    logic w_pre;
    logic w_cas;
    logic w_is_read;

    assign w_act     = !DRAM_CSn && !DRAM_RASn &&  r_rasn_q;
    assign w_pre     = !DRAM_CSn &&  DRAM_RASn && !r_rasn_q;
    assign w_cas     = !DRAM_CSn && !DRAM_CASn &&  r_casn_q;
    assign w_is_read = (DRAM_WEn == DRAM_WEN_READ);

    // ------------------------------------------------------------------
    // Bank state and timing qualifiers
    // ------------------------------------------------------------------
    dram_state_t r_state;
    dram_state_t w_state_nxt;

    logic w_trcd_ok;       // CAS allowed in ACTIVE
    logic w_trp_done;      // PRECHG may return to IDLE
    logic w_act_in_prechg; // activate during PRECHG is legal

`ifdef DRAM_TIMING_CHECK_EN
    localparam int TCW = 8;
    localparam logic [TCW-1:0] c_TRCD_LOAD = TCW'(T_RCD - 1);
    localparam logic [TCW-1:0] c_TRP_LOAD  = TCW'(T_RP - 1);

    // One counter serves both tRCD (in ACTIVE) and tRP (in PRECHG).
    logic [TCW-1:0] r_tcnt;

    assign w_trcd_ok       = (r_tcnt == '0);
    assign w_trp_done      = (r_tcnt == '0);
    assign w_act_in_prechg = 1'b0;
`else
    // Untimed build: the timing parameters only need to be sane.
    localparam bit c_UNTIMED_OK = (T_RCD > 0) && (T_RP > 0);

    assign w_trcd_ok       = c_UNTIMED_OK;
    assign w_trp_done      = c_UNTIMED_OK;
    // Precharge is already complete one cycle after it is issued, so an
    // activate arriving in that cycle opens the row.
    assign w_act_in_prechg = c_UNTIMED_OK;
`endif

    // ------------------------------------------------------------------
    // Read-path registers
    // ------------------------------------------------------------------
    logic [ROW_BITS-1:0] r_row;
    logic                r_rd_pend;
    logic [RCW-1:0]      r_rd_cnt;
    logic [DATA_W-1:0]   r_rd_data;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_act) begin
                    w_state_nxt = ACTIVE;
                end
            end
            ACTIVE: begin
                if (w_pre) begin
                    w_state_nxt = PRECHG;
                end
            end
            PRECHG: begin
                if (w_act && w_act_in_prechg) begin
                    w_state_nxt = ACTIVE;
                end else if (w_trp_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: command qualification
    // ------------------------------------------------------------------
    logic w_row_load;
    logic w_cas_ok;
    logic w_viol;

    always_comb begin
        w_row_load = 1'b0;
        w_cas_ok   = 1'b0;
        w_viol     = 1'b0;
        case (r_state)
            IDLE: begin
                // A CAS in the same cycle as the activate sees a closed row.
                w_row_load = w_act;
                w_viol     = w_cas;
            end
            ACTIVE: begin
                // A coincident precharge does not block the CAS: the open
                // row is used and the precharge is taken afterwards.
                if (w_cas) begin
                    if (!w_trcd_ok || (w_is_read && r_rd_pend)) begin
                        w_viol = 1'b1;
                    end else begin
                        w_cas_ok = 1'b1;
                    end
                end
            end
            PRECHG: begin
                if (w_act) begin
                    if (w_act_in_prechg) begin
                        w_row_load = 1'b1;
                    end else begin
                        w_viol = 1'b1;
                    end
                end
                if (w_cas) begin
                    w_viol = 1'b1;
                end
            end
            default: begin
                w_row_load = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [MEM_AW-1:0] w_idx;
    logic [NBYTES-1:0] w_we;
    logic [DATA_W-1:0] w_arr_rdata;
    logic              w_rd_acc;

    assign w_idx    = MEM_AW'({r_row, DRAM_A[COL_BITS-1:0]});
    assign w_we     = (w_cas_ok && !w_is_read) ? ~DRAM_WEn : '0;
    assign w_rd_acc = w_cas_ok && w_is_read;

    dram_bank_array #(
        .AW (MEM_AW)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (DRAM_D),
        .i_raddr (w_idx),
        .o_rdata (w_arr_rdata)
    );

    // ------------------------------------------------------------------
    // Datapath: strobes, row latch, read pipeline, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rasn_q   <= 1'b1;
            r_casn_q   <= 1'b1;
            r_row      <= '0;
            r_rd_pend  <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_data  <= '0;
            DRAM_Q     <= '0;
            DRAM_valid <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            r_rasn_q   <= DRAM_RASn;
            r_casn_q   <= DRAM_CASn;
            DRAM_valid <= 1'b0;

            if (w_row_load) begin
                r_row <= DRAM_A;
            end

            if (w_viol) begin
                proto_err <= 1'b1;
            end

            // Data is snapshotted at CAS time so later writes to the same
            // word cannot disturb the in-flight read.
            if (w_rd_acc) begin
                r_rd_pend <= 1'b1;
                r_rd_cnt  <= c_RD_LOAD;
                r_rd_data <= w_arr_rdata;
            end else if (r_rd_pend) begin
                if (r_rd_cnt == '0) begin
                    r_rd_pend  <= 1'b0;
                    DRAM_valid <= 1'b1;
                    DRAM_Q     <= r_rd_data;
                end else begin
                    r_rd_cnt <= r_rd_cnt - 1'b1;
                end
            end
        end
    end

`ifdef DRAM_TIMING_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_row_load) begin
            r_tcnt <= c_TRCD_LOAD;
        end else if (r_state == ACTIVE && w_pre) begin
            r_tcnt <= c_TRP_LOAD;
        end else if (r_tcnt != '0) begin
            r_tcnt <= r_tcnt - 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dram_device_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dram_device_model
//  Purpose  : Directed self-checking bench for dram_device_model. Expected
//             values are hand-computed; those that depend on timing
//             enforcement follow DRAM_TIMING_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dram_device_model;
    import dram_pkg::*;

`ifdef DRAM_TIMING_CHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        csn;
    logic        rasn;
    logic        casn;
    logic [3:0]  wen;
    logic [10:0] a;
    logic [31:0] d;
    logic [31:0] q;
    logic        valid;
    logic        perr;

    int n_checks = 0;
    int n_errors = 0;

    int          w_cnt;
    int          w_first;
    logic [31:0] w_q;

    always #5 clk = ~clk;

    dram_device_model dut (
        .clk        (clk),
        .rst        (rst),
        .DRAM_CSn   (csn),
        .DRAM_RASn  (rasn),
        .DRAM_CASn  (casn),
        .DRAM_WEn   (wen),
        .DRAM_A     (a),
        .DRAM_D     (d),
        .DRAM_Q     (q),
        .DRAM_valid (valid),
        .proto_err  (perr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; inputs change 1ns after the edge, outputs read there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        rasn = 1'b1;
        casn = 1'b1;
        wen  = 4'hF;
        cyc();
        rst  = 1'b0;
    endtask

    task automatic activate(input logic [10:0] row);
        rasn = 1'b0;
        a    = row;
        cyc();
    endtask

    task automatic precharge();
        rasn = 1'b1;
        cyc();
    endtask

    task automatic cas(input logic [10:0] col, input logic [3:0] we, input logic [31:0] data);
        casn = 1'b0;
        a    = col;
        wen  = we;
        d    = data;
        cyc();
        casn = 1'b1;
        wen  = 4'hF;
    endtask

    // Observe n cycles: number of valid pulses, cycle of the first, its data.
    task automatic watch(input int n, output int cnt, output int first, output logic [31:0] qv);
        cnt   = 0;
        first = -1;
        qv    = '0;
        for (int i = 1; i <= n; i++) begin
            cyc();
            if (valid) begin
                if (cnt == 0) begin
                    first = i;
                    qv    = q;
                end
                cnt++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; csn = 1'b0; rasn = 1'b1; casn = 1'b1;
        wen = 4'hF; a = '0; d = '0;
        cyc();
        do_reset();

        // Reset state
        check("reset_q",     q,            32'h0);
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_err",   {31'b0, perr},  32'h0);

        // Write then read
        activate(11'h005);
        nop(1);
        cas(11'h010, 4'h0, 32'hDEADBEEF);
        nop(1);
        cas(11'h020, 4'h0, 32'h01234567);
        nop(1);
        precharge();
        nop(3);
        activate(11'h005);
        nop(1);
        cas(11'h010, 4'hF, 32'h0);
        nop(4);
        check("wr_rd_early_valid", {31'b0, valid}, 32'h0);
        nop(1);
        check("wr_rd_valid", {31'b0, valid}, 32'h1);
        check("wr_rd_q",     q,              32'hDEADBEEF);
        nop(1);
        check("wr_rd_valid_drop", {31'b0, valid}, 32'h0);
        check("wr_rd_q_hold",     q,              32'hDEADBEEF);
        check("wr_rd_err",        {31'b0, perr},  32'h0);

        // Byte mask, then a write racing an in-flight read
        cas(11'h010, 4'b1010, 32'h11223344);
        nop(1);
        cas(11'h010, 4'hF, 32'h0);
        nop(1);
        cas(11'h010, 4'h0, 32'hCAFEF00D);
        nop(3);
        check("bmask_valid", {31'b0, valid}, 32'h1);
        check("bmask_q",     q,              32'hDE22BE44);
        nop(1);
        cas(11'h010, 4'hF, 32'h0);
        nop(5);
        check("late_wr_valid", {31'b0, valid}, 32'h1);
        check("late_wr_q",     q,              32'hCAFEF00D);
        check("bmask_err",     {31'b0, perr},  32'h0);
        precharge();
        nop(3);

        // tRCD: CAS one cycle after activate
        do_reset();
        activate(11'h005);
        cas(11'h020, 4'h0, 32'h55AA55AA);
        check("trcd_err", {31'b0, perr}, {31'b0, TC});
        check("trcd_no_valid", {31'b0, valid}, 32'h0);
        nop(1);
        cas(11'h020, 4'hF, 32'h0);
        nop(5);
        check("trcd_rd_valid", {31'b0, valid}, 32'h1);
        check("trcd_rd_q", q, TC ? 32'h01234567 : 32'h55AA55AA);
        precharge();
        nop(3);

        // tRP: activate one cycle after precharge, then a read CAS
        do_reset();
        activate(11'h005);
        nop(1);
        precharge();
        activate(11'h005);
        check("trp_err", {31'b0, perr}, {31'b0, TC});
        nop(3);
        cas(11'h010, 4'hF, 32'h0);
        watch(7, w_cnt, w_first, w_q);
        check("trp_pulses", w_cnt, TC ? 32'd0 : 32'd1);
        check("trp_q", w_q, TC ? 32'h0 : 32'hCAFEF00D);
        check("trp_err_after_cas", {31'b0, perr}, {31'b0, TC});
        precharge();
        nop(3);

        // Overlapping read
        do_reset();
        activate(11'h005);
        nop(1);
        cas(11'h010, 4'hF, 32'h0);
        nop(1);
        cas(11'h020, 4'hF, 32'h0);
        watch(8, w_cnt, w_first, w_q);
        check("ovl_pulses", w_cnt,   32'd1);
        check("ovl_cycle",  w_first, 32'd3);
        check("ovl_q",      w_q,     32'hCAFEF00D);
        check("ovl_err",    {31'b0, perr}, 32'h1);
        precharge();
        nop(3);

        // Precharge and CAS in the same cycle
        do_reset();
        activate(11'h005);
        nop(1);
        rasn = 1'b1;
        casn = 1'b0;
        a    = 11'h020;
        wen  = 4'hF;
        cyc();
        casn = 1'b1;
        watch(6, w_cnt, w_first, w_q);
        check("precas_pulses", w_cnt,   32'd1);
        check("precas_cycle",  w_first, 32'd5);
        check("precas_q",      w_q, TC ? 32'h01234567 : 32'h55AA55AA);
        check("precas_err",    {31'b0, perr}, 32'h0);
        nop(3);

        // Activate and CAS together from IDLE
        do_reset();
        rasn = 1'b0;
        casn = 1'b0;
        a    = 11'h005;
        wen  = 4'hF;
        cyc();
        casn = 1'b1;
        check("actcas_err", {31'b0, perr}, 32'h1);
        watch(6, w_cnt, w_first, w_q);
        check("actcas_pulses", w_cnt, 32'd0);
        precharge();
        nop(3);

        // Reset two cycles after a read CAS
        do_reset();
        activate(11'h005);
        nop(1);
        cas(11'h010, 4'hF, 32'h0);
        nop(1);
        rst  = 1'b1;
        rasn = 1'b1;
        cyc();
        rst  = 1'b0;
        watch(6, w_cnt, w_first, w_q);
        check("rstrd_pulses", w_cnt, 32'd0);
        check("rstrd_q",      q,     32'h0);
        check("rstrd_err",    {31'b0, perr}, 32'h0);
        cas(11'h010, 4'hF, 32'h0);
        check("rstrd_idle_cas_err", {31'b0, perr}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
